// File: rtl/wheel_pkg.sv
// Shared definitions for the wheel stepper drive channel.
//   - state_e      : channel FSM states (IDLE / RUN / DECEL)
//   - COIL_TABLE   : 8-entry phase -> coil drive pattern table, entry n at bits [4n+3:4n]
//   - coil_of()    : look up the coil pattern for a phase
//   - mag_max()    : largest speed magnitude for a given command width
//   - target_period(): step period (clk cycles) requested by a non-zero magnitude
package wheel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DECEL = 2'd2
    } state_e;

    // Unipolar half-step sequence; even phases energise one coil, odd phases two.
    localparam logic [31:0] COIL_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

    function automatic logic [3:0] coil_of(input logic [2:0] phase);
        return COIL_TABLE[{phase, 2'b00} +: 4];
    endfunction

    function automatic int mag_max(input int speed_w);
        return (32'sd1 <<< (speed_w - 32'sd1)) - 32'sd1;
    endfunction

    // Fastest period at full magnitude, one PERIOD_STEP slower per unit below it.
    function automatic int target_period(input int mag, input int mag_top,
                                         input int period_min, input int period_step);
        return period_min + (mag_top - mag) * period_step;
    endfunction

endpackage

// File: rtl/wheel_stepper_ramp_timer.sv
// step_ramp_timer: step-interval divider with trapezoidal period ramp.
//   clk, rst      : clock, synchronous active-high reset
//   enable_i      : 0 forces divider to 0 and period back to PERIOD_MAX
//   run_i         : 1 while the channel is stepping; 0 holds the divider at 0
//   target_i      : period the ramp is heading toward (from the FSM)
//   step_o        : step event, high during the terminal-count cycle
//   cur_period_o  : interval currently being timed
module step_ramp_timer
    import wheel_pkg::*;
#(
    parameter int DIV_W      = 20,
    parameter int PERIOD_MAX = 50000,
    parameter int PERIOD_MIN = 5000,
    parameter int RAMP_DELTA = 500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] target_i,
    output logic             step_o,
    output logic [DIV_W-1:0] cur_period_o
);

    localparam logic [DIV_W-1:0] PMAX_V  = DIV_W'(PERIOD_MAX);
    localparam logic [DIV_W-1:0] PMIN_V  = DIV_W'(PERIOD_MIN);
    localparam logic [DIV_W-1:0] DELTA_V = DIV_W'(RAMP_DELTA);

    logic [DIV_W-1:0] divider_q;
    logic [DIV_W-1:0] divider_d;
    logic [DIV_W-1:0] cur_period_q;
    logic [DIV_W-1:0] cur_period_d;
    logic [DIV_W-1:0] ramped_s;
    logic [DIV_W-1:0] period_next_s;

    assign step_o       = enable_i && run_i && (divider_q == (cur_period_q - DIV_W'(1)));
    assign cur_period_o = cur_period_q;

    // Ramp: move one RAMP_DELTA toward target without overshooting, then clamp to legal range.
    always_comb begin
        ramped_s      = cur_period_q;
        period_next_s = cur_period_q;
        if (cur_period_q > target_i) begin
            if ((cur_period_q - target_i) > DELTA_V) begin
                ramped_s = cur_period_q - DELTA_V;
            end else begin
                ramped_s = target_i;
            end
        end else if (cur_period_q < target_i) begin
            if ((target_i - cur_period_q) > DELTA_V) begin
                ramped_s = cur_period_q + DELTA_V;
            end else begin
                ramped_s = target_i;
            end
        end else begin
            ramped_s = cur_period_q;
        end
        if (ramped_s > PMAX_V) begin
            period_next_s = PMAX_V;
        end else if (ramped_s < PMIN_V) begin
            period_next_s = PMIN_V;
        end else begin
            period_next_s = ramped_s;
        end
    end

    // Divider / period next-state: coast resets everything, idle parks the divider.
    always_comb begin
        divider_d    = divider_q;
        cur_period_d = cur_period_q;
        if (!enable_i) begin
            divider_d    = '0;
            cur_period_d = PMAX_V;
        end else if (!run_i) begin
            divider_d    = '0;
        end else if (step_o) begin
            // New period applies to the interval that starts now.
            divider_d    = '0;
            cur_period_d = period_next_s;
        end else begin
            divider_d    = divider_q + DIV_W'(1);
        end
    end

    // Divider and period registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            divider_q    <= '0;
            cur_period_q <= PMAX_V;
        end else begin
            divider_q    <= divider_d;
            cur_period_q <= cur_period_d;
        end
    end

endmodule

// File: rtl/wheel_stepper_ramp.sv
// wheel_stepper_ramp: one wheel's stepper drive channel.
// Converts a sign-magnitude speed command into a unipolar 4-coil step sequence
// with a trapezoidal period ramp; direction reversals always decelerate to the
// start/stop period before the direction flips. Keeps a wrapping tick count.
//   clk, rst    : clock, synchronous active-high reset
//   enable      : 0 = coast (coils off, ramp reset)
//   speed_cmd   : MSB = direction (1 = reverse), low bits = magnitude
//   half_step   : 1 = 8-phase half-step, 0 = 4-phase full-step
//   tick_clear  : synchronous clear of tick_count (wins over a step)
//   coils       : registered coil drive pattern
//   tick_count  : up/down step count, wraps modulo 2^TICK_W
//   step_pulse  : one-cycle pulse per step, aligned with the coil update
//   moving      : 1 while not IDLE
//   dir_out     : current physical direction
module wheel_stepper_ramp
    import wheel_pkg::*;
#(
    parameter int SPEED_W     = 3,
    parameter int TICK_W      = 8,
    parameter int DIV_W       = 20,
    parameter int PERIOD_MAX  = 50000,
    parameter int PERIOD_MIN  = 5000,
    parameter int PERIOD_STEP = 5000,
    parameter int RAMP_DELTA  = 500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [SPEED_W-1:0] speed_cmd,
    input  logic               half_step,
    input  logic               tick_clear,
    output logic [3:0]         coils,
    output logic [TICK_W-1:0]  tick_count,
    output logic               step_pulse,
    output logic               moving,
    output logic               dir_out
);

    localparam int MAG_MAX = mag_max(SPEED_W);
    localparam logic [DIV_W-1:0] PMAX_V = DIV_W'(PERIOD_MAX);

    // Slowest running target (magnitude 1) must not exceed the start/stop period.
    if (SPEED_W < 2) begin : g_bad_speed_w
        $error("wheel_stepper_ramp: SPEED_W must be at least 2");
    end
    if (PERIOD_MIN < 1 || PERIOD_MIN > PERIOD_MAX) begin : g_bad_period_min
        $error("wheel_stepper_ramp: PERIOD_MIN out of range");
    end
    if (target_period(1, MAG_MAX, PERIOD_MIN, PERIOD_STEP) > PERIOD_MAX) begin : g_bad_target
        $error("wheel_stepper_ramp: slowest target period exceeds PERIOD_MAX");
    end
    if (PERIOD_MAX >= (64'd1 << DIV_W)) begin : g_bad_div_w
        $error("wheel_stepper_ramp: DIV_W too narrow for PERIOD_MAX");
    end

    state_e              state_q;
    state_e              state_d;
    logic                dir_q;
    logic                dir_d;
    logic [2:0]          phase_q;
    logic [2:0]          phase_d;
    logic [3:0]          coils_q;
    logic [3:0]          coils_d;
    logic [TICK_W-1:0]   tick_q;
    logic [TICK_W-1:0]   tick_d;
    logic                step_pulse_q;
    logic                step_pulse_d;
    logic                moving_q;
    logic                moving_d;

    logic                cmd_dir_s;
    logic [SPEED_W-2:0]  mag_s;
    logic                cmd_ok_s;
    logic                step_s;
    logic [DIV_W-1:0]    cur_period_s;
    logic [DIV_W-1:0]    target_s;
    logic [2:0]          adv_s;
    logic [2:0]          phase_step_s;

    assign cmd_dir_s = speed_cmd[SPEED_W-1];
    assign mag_s     = speed_cmd[SPEED_W-2:0];
    // Command still asks for motion in the direction we are already turning.
    assign cmd_ok_s  = (mag_s != '0) && (cmd_dir_s == dir_q);

    // Ramp target: commanded speed only while running on-command; otherwise slow to stop.
    always_comb begin
        target_s = PMAX_V;
        if (state_q == RUN && cmd_ok_s) begin
            target_s = DIV_W'(target_period(int'(mag_s), MAG_MAX, PERIOD_MIN, PERIOD_STEP));
        end else begin
            target_s = PMAX_V;
        end
    end

    // Phase advance; full-step from an odd phase moves one to realign on even phases.
    always_comb begin
        adv_s = 3'd1;
        if (half_step || phase_q[0]) begin
            adv_s = 3'd1;
        end else begin
            adv_s = 3'd2;
        end
        if (dir_q) begin
            phase_step_s = phase_q - adv_s;
        end else begin
            phase_step_s = phase_q + adv_s;
        end
    end

    step_ramp_timer #(
        .DIV_W      (DIV_W),
        .PERIOD_MAX (PERIOD_MAX),
        .PERIOD_MIN (PERIOD_MIN),
        .RAMP_DELTA (RAMP_DELTA)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable),
        .run_i        (state_q != IDLE),
        .target_i     (target_s),
        .step_o       (step_s),
        .cur_period_o (cur_period_s)
    );

    // FSM next state plus step-event effects on phase, coils and tick count.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        phase_d      = phase_q;
        coils_d      = coils_q;
        tick_d       = tick_q;
        step_pulse_d = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            coils_d = 4'b0000;
        end else begin
            if (step_s) begin
                step_pulse_d = 1'b1;
                phase_d      = phase_step_s;
                coils_d      = coil_of(phase_step_s);
                if (dir_q) begin
                    tick_d = tick_q - TICK_W'(1);
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end else begin
                step_pulse_d = 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (mag_s != '0) begin
                        dir_d   = cmd_dir_s;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (!cmd_ok_s) begin
                        state_d = DECEL;
                    end else begin
                        state_d = RUN;
                    end
                end
                DECEL: begin
                    if (cmd_ok_s) begin
                        // Command came back to our direction: resume without stopping.
                        state_d = RUN;
                    end else if (step_s && (cur_period_s == PMAX_V)) begin
                        if (mag_s == '0) begin
                            state_d = IDLE;
                        end else begin
                            dir_d   = cmd_dir_s;
                            state_d = RUN;
                        end
                    end else begin
                        state_d = DECEL;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        if (tick_clear) begin
            tick_d = '0;
        end else begin
            tick_d = tick_d;
        end
        moving_d = (state_d != IDLE);
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dir_q        <= 1'b0;
            phase_q      <= 3'd0;
            coils_q      <= 4'b0000;
            tick_q       <= '0;
            step_pulse_q <= 1'b0;
            moving_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            phase_q      <= phase_d;
            coils_q      <= coils_d;
            tick_q       <= tick_d;
            step_pulse_q <= step_pulse_d;
            moving_q     <= moving_d;
        end
    end

    assign coils      = coils_q;
    assign tick_count = tick_q;
    assign step_pulse = step_pulse_q;
    assign moving     = moving_q;
    assign dir_out    = dir_q;

endmodule

// File: tb/tb_wheel_stepper_ramp.sv
// Bench for wheel_stepper_ramp: directed scenarios plus random stimulus, with a
// step-schedule model (absolute cycle of next step) checked every cycle.
module tb_wheel_stepper_ramp;

    localparam int P_MAX  = 20;
    localparam int P_MIN  = 4;
    localparam int P_STEP = 4;
    localparam int DELTA  = 4;
    localparam int MAGMAX = 3;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DECEL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] speed_cmd = 3'b000;
    logic       half_step = 1'b1;
    logic       tick_clear = 1'b0;
    logic [3:0] coils;
    logic [7:0] tick_count;
    logic       step_pulse;
    logic       moving;
    logic       dir_out;

    always #5 clk = ~clk;

    wheel_stepper_ramp #(
        .SPEED_W(3), .TICK_W(8), .DIV_W(20),
        .PERIOD_MAX(P_MAX), .PERIOD_MIN(P_MIN), .PERIOD_STEP(P_STEP), .RAMP_DELTA(DELTA)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .speed_cmd(speed_cmd),
        .half_step(half_step), .tick_clear(tick_clear), .coils(coils),
        .tick_count(tick_count), .step_pulse(step_pulse), .moving(moving), .dir_out(dir_out)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: each step is scheduled at an absolute cycle number.
    int m_cyc = 0, m_next = 0, m_mode = M_IDLE, m_dir = 0, m_phase = 0;
    int m_tick = 0, m_period = P_MAX, m_pulse = 0, m_coils = 0;
    int coil_tab[8] = '{1, 3, 2, 6, 4, 12, 8, 9};

    always @(posedge clk) begin
        int mag, cdir, ok, stepnow, tgt, was_max, adv;
        m_cyc++;
        if (rst) begin
            m_mode = M_IDLE; m_dir = 0; m_phase = 0; m_tick = 0;
            m_period = P_MAX; m_pulse = 0; m_coils = 0;
        end else if (!enable) begin
            m_coils = 0; m_pulse = 0; m_mode = M_IDLE; m_period = P_MAX;
            if (tick_clear) m_tick = 0;
        end else begin
            mag     = int'(speed_cmd[1:0]);
            cdir    = int'(speed_cmd[2]);
            ok      = (mag != 0 && cdir == m_dir) ? 1 : 0;
            stepnow = (m_mode != M_IDLE && m_cyc == m_next) ? 1 : 0;
            tgt     = (m_mode == M_RUN && ok) ? P_MIN + (MAGMAX - mag) * P_STEP : P_MAX;
            was_max = (m_period == P_MAX) ? 1 : 0;
            m_pulse = 0;
            if (stepnow) begin
                adv     = (half_step || (m_phase % 2 == 1)) ? 1 : 2;
                m_phase = m_dir ? (m_phase + 8 - adv) % 8 : (m_phase + adv) % 8;
                m_coils = coil_tab[m_phase];
                m_tick  = m_dir ? (m_tick + 255) % 256 : (m_tick + 1) % 256;
                if (m_period > tgt) m_period = (m_period - DELTA > tgt) ? m_period - DELTA : tgt;
                else                m_period = (m_period + DELTA < tgt) ? m_period + DELTA : tgt;
                m_next  = m_cyc + m_period;
                m_pulse = 1;
            end
            if (m_mode == M_IDLE) begin
                if (mag != 0) begin m_dir = cdir; m_mode = M_RUN; m_next = m_cyc + P_MAX; end
            end else if (m_mode == M_RUN) begin
                if (!ok) m_mode = M_DECEL;
            end else begin
                if (ok) m_mode = M_RUN;
                else if (stepnow && was_max) begin
                    if (mag == 0) m_mode = M_IDLE;
                    else begin m_dir = cdir; m_mode = M_RUN; end
                end
            end
            if (tick_clear) m_tick = 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("coils", int'(coils), m_coils);
            check("tick_count", int'(tick_count), m_tick);
            check("step_pulse", int'(step_pulse), m_pulse);
            check("moving", int'(moving), (m_mode != M_IDLE) ? 1 : 0);
            check("dir_out", int'(dir_out), m_dir);
        end
    end

    task automatic wait_pulse(output int dt);
        dt = 0;
        do begin
            @(negedge clk);
            dt++;
        end while (step_pulse !== 1'b1 && dt < 200);
        if (step_pulse !== 1'b1) check("pulse_timeout", 0, 1);
    endtask

    int exp_dt1[6]   = '{21, 16, 12, 8, 4, 4};
    int exp_coil1[6] = '{3, 2, 6, 4, 8, 1};
    int exp_dt2[5]   = '{4, 8, 12, 16, 20};
    int exp_dt3[5]   = '{21, 16, 12, 8, 8};

    initial begin
        int dt, found, guard;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_coils", int'(coils), 0);
        check("reset_tick", int'(tick_count), 0);
        check("reset_moving", int'(moving), 0);
        check("reset_dir", int'(dir_out), 0);
        check("reset_pulse", int'(step_pulse), 0);
        rst = 1'b0;
        @(negedge clk);

        // Accelerate at mag 3, switch to full-step at phase 3.
        enable = 1'b1; speed_cmd = 3'b011; half_step = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_pulse(dt);
            check("t1_interval", dt, exp_dt1[i]);
            check("t1_coils", int'(coils), exp_coil1[i]);
            check("t1_tick", int'(tick_count), i + 1);
            if (i == 2) half_step = 1'b0;
        end

        // Stop: decelerate to the start/stop period, last step then idle.
        speed_cmd = 3'b000;
        for (int i = 0; i < 5; i++) begin
            wait_pulse(dt);
            check("t2_interval", dt, exp_dt2[i]);
        end
        check("t2_stopped", int'(moving), 0);
        repeat (30) @(negedge clk);

        // Forward at mag 2 then reverse request.
        half_step = 1'b1; speed_cmd = 3'b010;
        for (int i = 0; i < 5; i++) begin
            wait_pulse(dt);
            check("t3_interval", dt, exp_dt3[i]);
        end
        speed_cmd = 3'b110;
        guard = 0;
        while (dir_out !== 1'b1 && guard < 300) begin @(negedge clk); guard++; end
        check("t3_reversed", int'(dir_out), 1);
        for (int i = 0; i < 3; i++) wait_pulse(dt);

        // Tick wrap both ways, then clear coincident with a step.
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        speed_cmd = 3'b111;
        wait_pulse(dt);
        check("t5_first_latency", dt, 21);
        check("t5_tick_255", int'(tick_count), 255);
        speed_cmd = 3'b011;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            wait_pulse(dt);
            if (tick_count == 8'd0) found = 1;
        end
        check("t5_wrap_to_0", found, 1);
        check("t5_wrap_dir", int'(dir_out), 0);
        wait_pulse(dt);
        guard = 0;
        while (m_cyc != m_next - 1 && guard < 200) begin @(negedge clk); guard++; end
        tick_clear = 1'b1;
        @(negedge clk);
        tick_clear = 1'b0;
        check("t5_clear_pulse", int'(step_pulse), 1);
        check("t5_clear_tick", int'(tick_count), 0);

        // Coast mid-run, then reset mid-decel.
        enable = 1'b0;
        @(negedge clk);
        check("t6_coast_coils", int'(coils), 0);
        check("t6_coast_moving", int'(moving), 0);
        repeat (5) @(negedge clk);
        enable = 1'b1; speed_cmd = 3'b011;
        wait_pulse(dt);
        wait_pulse(dt);
        speed_cmd = 3'b111;
        repeat (3) @(negedge clk);
        check("t6_moving_before_rst", int'(moving), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_coils", int'(coils), 0);
        check("t6_rst_tick", int'(tick_count), 0);
        check("t6_rst_moving", int'(moving), 0);
        check("t6_rst_dir", int'(dir_out), 0);
        check("t6_rst_pulse", int'(step_pulse), 0);
        rst = 1'b0;

        // Random stimulus against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) speed_cmd = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0) half_step = ~half_step;
            if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
            tick_clear = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
